multdiv_iter: RTL and testbench

Iterative signed multiply/divide unit for the DX stage of the 5-stage pipeline. It consumes the operand pair and destination register selected in DX for R-type mul (ALU op 00110) and div (ALU op 00111). It produces a registered 32-bit result, an exception flag and a destination tag, which the pipeline forwards into XM/MW. While an operation is in flight it holds `busy` high so the hazard logic can stall FD/DX.

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_counter.sv | 33 +++
 rtl/multdiv_iter.sv | 173 +++++++++++++++++
 tb/tb_multdiv_iter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: state encoding,
// ALU op codes and the default datapath width.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter: counts 0..WIDTH-1 without wrapping, synchronous clear,
// terminal flag on the last iteration.
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int CNT_W = 6,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_LAST)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign tc = (cnt == CNT_LAST);

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit for DX.
// One bit per clock; result, exception and destination tag are registered.
//
//   state | meaning
//   IDLE  | waiting for a start pulse
//   MULT  | Booth iterations, then result registration
//   DIV   | shift-subtract iterations, then result registration
//   DONE  | data_resultRDY cycle
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [4:0]       in_rd,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy,
    output logic [4:0]       out_rd
);

    state_t             state;
    logic [2*WIDTH:0]   prod_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               q_neg;
    logic [4:0]         rd_q;
    logic               last_q;
    logic               tc;

    logic               start_mul;
    logic               start_div;
    logic               in_op;
    logic [WIDTH:0]     acc_ext;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH:0]   booth_next;
    logic [2*WIDTH-1:0] product;
    logic               mul_ovf;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   quo_signed;
    logic               div_ovf;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign start_mul = ctrl_MULT;
    assign start_div = ctrl_DIV && !ctrl_MULT;
    assign in_op     = (state == MULT) || (state == DIV);

    multdiv_counter #(.CNT_W(CNT_W), .WIDTH(WIDTH)) u_counter (
        .clock (clock),
        .reset (reset),
        .clr   (ctrl_MULT || ctrl_DIV),
        .en    (in_op),
        .tc    (tc)
    );

    // One guard bit on the Booth adder keeps the INT_MIN multiplicand exact.
    assign acc_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    assign a_ext   = {a_q[WIDTH-1], a_q};

    always_comb begin
        booth_sum = acc_ext;
        case (prod_q[1:0])
            2'b01:   booth_sum = acc_ext + a_ext;
            2'b10:   booth_sum = acc_ext - a_ext;
            default: ;
        endcase
    end

    assign booth_next = {booth_sum, prod_q[WIDTH:1]};
    assign product    = prod_q[2*WIDTH:1];
    assign mul_ovf    = product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}};

    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial difference.
    assign div_shift  = {rem_q, quo_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, dvs_q};
    assign quo_signed = q_neg ? -quo_q : quo_q;
    assign div_ovf    = !q_neg && quo_q[WIDTH-1];

    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            prod_q         <= '0;
            a_q            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvs_q          <= '0;
            q_neg          <= 1'b0;
            rd_q           <= '0;
            last_q         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
            out_rd         <= '0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start_mul) begin
                state  <= MULT;
                a_q    <= data_operandA;
                prod_q <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                rd_q   <= in_rd;
                last_q <= 1'b0;
                busy   <= 1'b1;
            end else if (start_div) begin
                rd_q   <= in_rd;
                last_q <= 1'b0;
                if (data_operandB == '0) begin
                    state          <= DONE;
                    busy           <= 1'b0;
                    data_result    <= '0;
                    data_exception <= 1'b1;
                    data_resultRDY <= 1'b1;
                    out_rd         <= in_rd;
                end else begin
                    state <= DIV;
                    busy  <= 1'b1;
                    rem_q <= '0;
                    quo_q <= mag_a;
                    dvs_q <= mag_b;
                    q_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                end
            end else begin
                case (state)
                    MULT: begin
                        if (!last_q) begin
                            prod_q <= booth_next;
                            last_q <= tc;
                        end else begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_result    <= mul_ovf ? '0 : product[WIDTH-1:0];
                            data_exception <= mul_ovf;
                            data_resultRDY <= 1'b1;
                            out_rd         <= rd_q;
                        end
                    end
                    DIV: begin
                        if (!last_q) begin
                            rem_q  <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                            quo_q  <= {quo_q[WIDTH-2:0], !div_diff[WIDTH]};
                            last_q <= tc;
                        end else begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_result    <= div_ovf ? '0 : quo_signed;
                            data_exception <= div_ovf;
                            data_resultRDY <= 1'b1;
                            out_rd         <= rd_q;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: directed operations push expected results,
// a negedge monitor pops and checks on every data_resultRDY.
module tb_multdiv_iter;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mul;
    logic        dv;
    logic [4:0]  rd_in;
    logic [31:0] result;
    logic        exc;
    logic        rdy;
    logic        busy;
    logic [4:0]  rd_out;

    int   cyc;
    int   total;
    int   bad;
    exp_t sb[$];

    multdiv_iter dut (
        .clock          (clk),
        .reset          (rst_n),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .ctrl_MULT      (mul),
        .ctrl_DIV       (dv),
        .in_rd          (rd_in),
        .data_result    (result),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy),
        .out_rd         (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst_n && rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdy: RDY at cycle %0d, no operation outstanding", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                total += 4;
                if (result !== e.res) begin
                    bad++;
                    $display("FAIL result: got %h expected %h", result, e.res);
                end
                if (exc !== e.exc) begin
                    bad++;
                    $display("FAIL exception: got %b expected %b", exc, e.exc);
                end
                if (rd_out !== e.rd) begin
                    bad++;
                    $display("FAIL out_rd: got %0d expected %0d", rd_out, e.rd);
                end
                if (cyc != e.cyc || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rdy_timing: rdy at cycle %0d busy=%b, expected cycle %0d busy=0",
                             cyc, busy, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic issue(input logic do_mul, input logic do_div,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input bit push, input logic [31:0] er, input logic ee, input int lat);
        exp_t e;
        @(negedge clk);
        opa   = a;
        opb   = b;
        rd_in = rd;
        mul   = do_mul;
        dv    = do_div;
        if (push) begin
            e.res = er;
            e.exc = ee;
            e.rd  = rd;
            e.cyc = cyc + 1 + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        mul   = 1'b0;
        dv    = 1'b0;
        opa   = $urandom;
        opb   = $urandom;
        rd_in = 5'($urandom);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d results still outstanding after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic count_busy(input int ncyc, output int nb);
        nb = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
    endtask

    initial begin
        int nb;
        int nr;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        opa   = 32'h0;
        opb   = 32'h0;
        mul   = 1'b0;
        dv    = 1'b0;
        rd_in = 5'd0;

        repeat (3) @(negedge clk);
        chk("reset_result", result, 32'h0);
        chk("reset_ctrl", {27'h0, exc, rdy, busy, 2'b0}, 32'h0);
        chk("reset_rd", {27'h0, rd_out}, 32'h0);
        rst_n = 1'b1;

        // 7 * -6, with busy-window length check
        issue(1'b1, 1'b0, 32'd7, -32'sd6, 5'd9, 1'b1, 32'hFFFF_FFD6, 1'b0, 33);
        count_busy(40, nb);
        chk("mul_busy_cycles", nb, 33);
        drain(10);

        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd3, 1'b1, 32'h0, 1'b1, 33);
        drain(45);
        issue(1'b1, 1'b0, -32'sd3, -32'sd5, 5'd4, 1'b1, 32'd15, 1'b0, 33);
        drain(45);
        issue(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_8000, 5'd5, 1'b1, 32'h8000_0000, 1'b0, 33);
        drain(45);
        issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 5'd6, 1'b1, 32'h0, 1'b1, 33);
        drain(45);

        issue(1'b0, 1'b1, -32'sd100, 32'd7, 5'd10, 1'b1, 32'hFFFF_FFF2, 1'b0, 33);
        drain(45);
        issue(1'b0, 1'b1, 32'd7, -32'sd2, 5'd11, 1'b1, 32'hFFFF_FFFD, 1'b0, 33);
        drain(45);
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'h0, 1'b1, 33);
        drain(45);

        // divide by zero completes immediately, busy never rises
        issue(1'b0, 1'b1, 32'd5, 32'd0, 5'd13, 1'b1, 32'h0, 1'b1, 0);
        count_busy(5, nb);
        chk("div0_busy_cycles", nb, 0);
        drain(5);

        // restart: multiply aborted by a divide 10 edges later
        issue(1'b1, 1'b0, 32'd3, 32'd4, 5'd14, 1'b0, 32'h0, 1'b0, 0);
        repeat (9) @(negedge clk);
        issue(1'b0, 1'b1, 32'd20, 32'd5, 5'd15, 1'b1, 32'd4, 1'b0, 33);
        drain(50);
        repeat (5) @(negedge clk);

        issue(1'b1, 1'b1, 32'd6, 32'd7, 5'd16, 1'b1, 32'd42, 1'b0, 33);
        drain(45);

        // asynchronous reset in the middle of a multiply
        issue(1'b1, 1'b0, 32'd9, 32'd9, 5'd17, 1'b0, 32'h0, 1'b0, 0);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_result", result, 32'h0);
        chk("midreset_ctrl", {27'h0, exc, rdy, busy, 2'b0}, 32'h0);
        chk("midreset_rd", {27'h0, rd_out}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nr = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (rdy) nr++;
        end
        chk("post_reset_no_rdy", nr, 0);

        issue(1'b1, 1'b0, 32'd2, 32'd3, 5'd18, 1'b1, 32'd6, 1'b0, 33);
        drain(45);
        chk("hold_result", result, 32'd6);
        chk("hold_rd", {27'h0, rd_out}, 32'd18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
